// File: rtl/xcvr_link_monitor.sv
// -----------------------------------------------------------------------------
// xcvr_link_monitor
//
// Multi-lane link-status monitor for the 10G SFP+ PHY datapath (PHY TX clock
// domain). For every lane the PHY status is reduced to a qualifier:
//   q[i] = qpll_lock & rx_block_lock[i] & ~rx_high_ber[i]
// The qualifier goes through a DOWN -> QUAL -> UP debounce FSM. The FSM drives:
//   - a link-up flag;
//   - a status LED: off when DOWN, flashing while qualifying, and on when UP,
//     with an off-blink after received-frame activity;
//   - an optional saturating counter of UP -> DOWN transitions.
//
// Optional feature macro: LINK_MON_STATS_EN
//   defined   : per-lane link-drop counters are implemented
//   undefined : no counter registers, link_down_count is tied to zero
//
// Parameters
//   CHANNELS        number of monitored lanes (1..16)
//   DEBOUNCE_CYCLES consecutive qualified cycles before link-up (>=2)
//   BLINK_CYCLES    LED off-time after activity / half-period of the QUAL flash
//   CNT_WIDTH       width of each link-drop counter
//
// Ports
//   clk             PHY TX clock, 156.25 MHz
//   rst             synchronous active-high reset
//   qpll_lock       shared QPLL lock
//   rx_block_lock   per-lane PHY block lock
//   rx_high_ber     per-lane PHY high-BER flag
//   rx_activity     per-lane single-cycle pulse per received frame
//   link_up         per-lane qualified link status
//   led             per-lane LED drive, active high
//   all_links_up    registered AND of link_up over all lanes
//   link_down_count per-lane drop counters, lane i at [i*CNT_WIDTH +: CNT_WIDTH]
// -----------------------------------------------------------------------------
module xcvr_link_monitor #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int BLINK_CYCLES    = 4096,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            qpll_lock,
  input  logic [CHANNELS-1:0]             rx_block_lock,
  input  logic [CHANNELS-1:0]             rx_high_ber,
  input  logic [CHANNELS-1:0]             rx_activity,
  output logic [CHANNELS-1:0]             link_up,
  output logic [CHANNELS-1:0]             led,
  output logic                            all_links_up,
  output logic [CHANNELS*CNT_WIDTH-1:0]   link_down_count
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    DOWN = 2'd0,
    QUAL = 2'd1,
    UP   = 2'd2
  } lane_state_t;

`ifdef LINK_MON_STATS_EN
  // Counters stick at all-ones so a flapping link never appears healthy again.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction
`endif

  logic [CHANNELS-1:0] qual;

  assign qual = {CHANNELS{qpll_lock}} & rx_block_lock & ~rx_high_ber;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    lane_state_t      state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             blk_act_q, blk_act_d;
    logic             led_q, led_d;

    // The blink timer is shared: free-running flash in QUAL, one-shot
    // activity blink in UP. Every state change restarts it.
    always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      blk_d     = blk_q;
      blk_act_d = blk_act_q;
      led_d     = led_q;
      unique case (state_q)
        DOWN: begin
          led_d     = 1'b0;
          blk_d     = '0;
          blk_act_d = 1'b0;
          if (qual[i]) begin
            state_d = QUAL;
            deb_d   = '0;
          end
        end
        QUAL: begin
          if (!qual[i]) begin
            state_d = DOWN;
            led_d   = 1'b0;
            blk_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d   = UP;
            led_d     = 1'b1;
            blk_d     = '0;
            blk_act_d = 1'b0;
          end else begin
            deb_d = deb_q + DEB_W'(1);
            if (blk_q == BLK_LAST) begin
              blk_d = '0;
              led_d = ~led_q;
            end else begin
              blk_d = blk_q + BLK_W'(1);
            end
          end
        end
        UP: begin
          if (!qual[i]) begin
            state_d   = DOWN;
            led_d     = 1'b0;
            blk_d     = '0;
            blk_act_d = 1'b0;
          end else if (blk_act_q) begin
            // Activity during an active blink is ignored (no retrigger).
            if (blk_q == BLK_LAST) begin
              blk_act_d = 1'b0;
              blk_d     = '0;
              led_d     = 1'b1;
            end else begin
              blk_d = blk_q + BLK_W'(1);
            end
          end else if (rx_activity[i]) begin
            blk_act_d = 1'b1;
            blk_d     = '0;
            led_d     = 1'b0;
          end
        end
        default: begin
          state_d   = DOWN;
          led_d     = 1'b0;
          blk_d     = '0;
          blk_act_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= DOWN;
        deb_q     <= '0;
        blk_q     <= '0;
        blk_act_q <= 1'b0;
        led_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        deb_q     <= deb_d;
        blk_q     <= blk_d;
        blk_act_q <= blk_act_d;
        led_q     <= led_d;
      end
    end

    assign link_up[i] = (state_q == UP);
    assign led[i]     = led_q;

`ifdef LINK_MON_STATS_EN
    logic                 drop;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign drop = (state_q == UP) && !qual[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (drop) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end

    assign link_down_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`else
    assign link_down_count[i*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      all_links_up <= 1'b0;
    end else begin
      all_links_up <= &link_up;
    end
  end

endmodule

// File: tb/tb_xcvr_link_monitor.sv
// -----------------------------------------------------------------------------
// tb_xcvr_link_monitor
//
// Directed bench for xcvr_link_monitor with CHANNELS=4, DEBOUNCE_CYCLES=16,
// BLINK_CYCLES=8, CNT_WIDTH=4. Reset and first qualification are table-driven.
// Drop, blink, QPLL loss, glitch and saturation are hand-written sequences.
// Expected drop counts are zero when LINK_MON_STATS_EN is not defined.
// -----------------------------------------------------------------------------
module tb_xcvr_link_monitor;

  localparam int CH  = 4;
  localparam int DEB = 16;
  localparam int BLK = 8;
  localparam int CW  = 4;

`ifdef LINK_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              qpll_lock;
  logic [CH-1:0]     rx_block_lock;
  logic [CH-1:0]     rx_high_ber;
  logic [CH-1:0]     rx_activity;
  logic [CH-1:0]     link_up;
  logic [CH-1:0]     led;
  logic              all_links_up;
  logic [CH*CW-1:0]  link_down_count;

  always #5 clk = ~clk;

  xcvr_link_monitor #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_CYCLES    (BLK),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .qpll_lock       (qpll_lock),
    .rx_block_lock   (rx_block_lock),
    .rx_high_ber     (rx_high_ber),
    .rx_activity     (rx_activity),
    .link_up         (link_up),
    .led             (led),
    .all_links_up    (all_links_up),
    .link_down_count (link_down_count)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt [CH];

  typedef struct {
    logic          r;
    logic [CH-1:0] hb;
    logic [CH-1:0] act;
    logic [CH-1:0] exp_lu;
    logic [CH-1:0] exp_led;
    logic          exp_all;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [CH*CW-1:0] cnt_vec();
    logic [CH*CW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      v[i*CW +: CW] = STATS ? CW'(exp_cnt[i]) : '0;
    end
    return v;
  endfunction

  task automatic bump(input int lane);
    if (exp_cnt[lane] < (1 << CW) - 1) exp_cnt[lane]++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    qpll_lock     = 1'b1;
    rx_block_lock = '1;
    rx_high_ber   = '1;
    rx_activity   = '1;
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;

    // Reset with all inputs high, then 18 edges of clean qualification.
    for (int k = 0; k < 4; k++) tbl[k] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
    for (int e = 1; e <= 18; e++) begin
      tbl[3+e] = '{1'b0, 4'h0, (e == 5) ? 4'hF : 4'h0,
                   (e >= 17) ? 4'hF : 4'h0,
                   (e >= 9)  ? 4'hF : 4'h0,
                   (e >= 18)};
    end

    for (int k = 0; k < 22; k++) begin
      rst         = tbl[k].r;
      rx_high_ber = tbl[k].hb;
      rx_activity = tbl[k].act;
      tick();
      chk($sformatf("vec%0d link_up", k), link_up, tbl[k].exp_lu);
      chk($sformatf("vec%0d led", k), led, tbl[k].exp_led);
      chk($sformatf("vec%0d all_links_up", k), all_links_up, tbl[k].exp_all);
      chk($sformatf("vec%0d count", k), link_down_count, cnt_vec());
    end
    rx_activity = '0;

    // Link drop on lane 2 via a one-cycle high-BER pulse.
    rx_high_ber[2] = 1'b1;
    tick();
    rx_high_ber = '0;
    bump(2);
    chk("drop link_up", link_up, 4'hB);
    chk("drop led", led, 4'hB);
    chk("drop count", link_down_count, cnt_vec());
    chk("drop all_links_up lag", all_links_up, 1'b1);
    tick();
    chk("drop all_links_up", all_links_up, 1'b0);
    for (int e = 2; e <= 16; e++) tick();
    chk("drop requal e16", link_up, 4'hB);
    tick();
    chk("drop requal e17", link_up, 4'hF);
    tick();
    chk("drop requal all", all_links_up, 1'b1);

    // Activity blink: lane 0 pulses at t=0 and t=3, lane 1 pulses at t=3.
    rx_activity[0] = 1'b1;
    tick();
    chk("blink t0 led", led, 4'hE);
    for (int k = 1; k <= 11; k++) begin
      rx_activity = (k == 3) ? 4'b0011 : 4'b0000;
      tick();
      chk($sformatf("blink t%0d led", k), led,
          {2'b11, !(k >= 3 && k <= 10), (k >= 8)});
    end
    rx_activity = '0;
    chk("blink link_up", link_up, 4'hF);

    // QPLL loss for 3 cycles.
    qpll_lock = 1'b0;
    tick();
    for (int i = 0; i < CH; i++) bump(i);
    chk("qpll link_up", link_up, 4'h0);
    chk("qpll led", led, 4'h0);
    chk("qpll count", link_down_count, cnt_vec());
    tick();
    tick();
    chk("qpll held count", link_down_count, cnt_vec());
    qpll_lock = 1'b1;
    for (int e = 1; e <= 16; e++) tick();
    chk("qpll requal e16", link_up, 4'h0);
    tick();
    chk("qpll requal e17", link_up, 4'hF);
    tick();
    chk("qpll requal all", all_links_up, 1'b1);

    // Reset while UP (rst wins), then a qualification glitch on lane 1.
    rst = 1'b1;
    tick();
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    chk("rst prio link_up", link_up, 4'h0);
    chk("rst prio led", led, 4'h0);
    chk("rst prio all", all_links_up, 1'b0);
    chk("rst prio count", link_down_count, cnt_vec());
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      rx_block_lock = (e == 12) ? 4'b1101 : 4'b1111;
      tick();
      if (e == 17) chk("glitch e17", link_up, 4'hD);
      if (e == 18) chk("glitch all e18", all_links_up, 1'b0);
      if (e == 28) chk("glitch e28", link_up, 4'hD);
      if (e == 29) chk("glitch e29", link_up, 4'hF);
      if (e == 30) chk("glitch all e30", all_links_up, 1'b1);
    end
    rx_block_lock = '1;
    chk("glitch count", link_down_count, cnt_vec());

    // Saturation: 20 drops on lane 3.
    for (int d = 1; d <= 20; d++) begin
      rx_high_ber[3] = 1'b1;
      tick();
      rx_high_ber = '0;
      bump(3);
      chk($sformatf("sat drop%0d link_up", d), link_up, 4'h7);
      if (d == 14 || d == 15 || d == 20) begin
        chk($sformatf("sat drop%0d count", d), link_down_count, cnt_vec());
      end
      for (int e = 1; e <= 17; e++) tick();
    end
    chk("sat final link_up", link_up, 4'hF);
    chk("sat final count", link_down_count, cnt_vec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
